// File: rtl/seg7_disp_ctrl.sv
// Memory-mapped 7-segment display controller: DATA/CTRL/STATUS registers, hex pass-through
// or sequential binary-to-BCD conversion, leading-zero and per-digit blanking.
module seg7_disp_ctrl #(
    parameter logic [31:0] DATA_RST = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_sel_i,
    input  logic              req_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       w_data_i,
    output logic [31:0]       r_data_o,
    output logic              ack_o,
    output logic [31:0]       disp_val_o,
    output logic [7:0]        disp_blank_o,
    output logic              disp_valid_o
);

    localparam logic [ADDR_W-1:0] OffData   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OffCtrl   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] OffStatus = ADDR_W'(8);
    localparam logic [31:0]       CtrlMask  = 32'h0001_FF03;

    typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

    state_e      state_q;
    logic [31:0] data_q, data_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic [31:0] bin_q;
    logic [39:0] bcd_q, bcd_nxt, bcd_shl;
    logic [4:0]  cnt_q;
    logic        trig_q, trig_w;
    logic [31:0] disp_val_q, disp_val_d;
    logic [7:0]  disp_blank_q, disp_blank_d;
    logic        disp_valid_q, disp_valid_d;
    logic        ack_q;
    logic [31:0] r_data_q, r_data_d;
    logic        xfer, wr, rd, busy, hex_load, dec_load, ovf_now;

    // Digit i (i >= 1) is blanked when it and every more significant nibble are zero.
    function automatic logic [7:0] lzb_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       z;
        m = 8'h00;
        z = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'h0);
            m[i] = z;
        end
        return m;
    endfunction

    always_comb begin
        xfer   = disp_sel_i & req_i;
        wr     = xfer & w_en_i;
        rd     = xfer & ~w_en_i;
        busy   = (state_q != StIdle);
        data_d = (wr && addr_i == OffData) ? w_data_i : data_q;
        ctrl_d = (wr && addr_i == OffCtrl) ? (w_data_i & CtrlMask) : ctrl_q;
        trig_w = (wr && addr_i == OffData) || (ctrl_d[0] != ctrl_q[0]);

        r_data_d = 32'h0;
        if (rd) begin
            if (addr_i == OffData) begin
                r_data_d = data_q;
            end else if (addr_i == OffCtrl) begin
                r_data_d = ctrl_q;
            end else if (addr_i == OffStatus) begin
                r_data_d = {30'h0, ovf_q, busy};
            end
        end
    end

    // Shift first, then pre-adjust digits for the next step; skipped after the final bit.
    always_comb begin
        bcd_shl = {bcd_q[38:0], bin_q[31]};
        bcd_nxt = bcd_shl;
        if (cnt_q != 5'd31) begin
            for (int d = 0; d < 10; d++) begin
                if (bcd_shl[4*d +: 4] >= 4'd5) begin
                    bcd_nxt[4*d +: 4] = bcd_shl[4*d +: 4] + 4'd3;
                end
            end
        end
    end

    always_comb begin
        ovf_now  = |bcd_q[39:32];
        hex_load = trig_q && !ctrl_q[0];
        dec_load = (state_q == StLoad) && !trig_w && !trig_q;

        disp_val_d   = disp_val_q;
        disp_valid_d = 1'b0;
        ovf_d        = ovf_q;
        if (hex_load) begin
            disp_val_d   = data_q;
            disp_valid_d = 1'b1;
            ovf_d        = 1'b0;
        end else if (dec_load) begin
            disp_val_d   = ovf_now ? 32'hFFFF_FFFF : bcd_q[31:0];
            disp_valid_d = 1'b1;
            ovf_d        = ovf_now;
        end

        if (!ctrl_d[16]) begin
            disp_blank_d = 8'hFF;
        end else begin
            disp_blank_d = ctrl_d[15:8] | (ctrl_d[1] ? lzb_mask(disp_val_d) : 8'h00);
        end
    end

    // A new trigger always wins: it parks the FSM in IDLE and the start happens one edge later
    // so the latest DATA and MODE are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            cnt_q   <= 5'd0;
            bin_q   <= 32'h0;
            bcd_q   <= 40'h0;
        end else if (trig_w) begin
            state_q <= StIdle;
            trig_q  <= 1'b1;
        end else if (trig_q) begin
            trig_q <= 1'b0;
            if (ctrl_q[0]) begin
                state_q <= StConv;
                bin_q   <= data_q;
                bcd_q   <= 40'h0;
                cnt_q   <= 5'd0;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            unique case (state_q)
                StConv: begin
                    bcd_q <= bcd_nxt;
                    bin_q <= {bin_q[30:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= StLoad;
                    end
                end
                StLoad:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= DATA_RST;
            ctrl_q       <= 32'h0;
            ovf_q        <= 1'b0;
            disp_val_q   <= 32'h0;
            disp_blank_q <= 8'hFF;
            disp_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            r_data_q     <= 32'h0;
        end else begin
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            ovf_q        <= ovf_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            disp_valid_q <= disp_valid_d;
            ack_q        <= xfer;
            r_data_q     <= r_data_d;
        end
    end

    assign r_data_o     = r_data_q;
    assign ack_o        = ack_q;
    assign disp_val_o   = disp_val_q;
    assign disp_blank_o = disp_blank_q;
    assign disp_valid_o = disp_valid_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Self-checking bench for seg7_disp_ctrl: register vector table plus conversion sequences,
// with bus acks and display pulses matched against scoreboard queues.
module tb_seg7_disp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] r_data;
    logic        ack;
    logic [31:0] disp_val;
    logic [7:0]  disp_blank;
    logic        disp_valid;

    seg7_disp_ctrl #(
        .DATA_RST(32'h0000_0000),
        .ADDR_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_sel_i  (sel),
        .req_i       (req),
        .w_en_i      (we),
        .addr_i      (addr),
        .w_data_i    (wdata),
        .r_data_o    (r_data),
        .ack_o       (ack),
        .disp_val_o  (disp_val),
        .disp_blank_o(disp_blank),
        .disp_valid_o(disp_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        logic [7:0]  blank;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] er;
    } vec_t;

    exp_t        rq[$];
    exp_t        dq[$];
    vec_t        tbl[19];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ctrl = 32'h0;
    logic [31:0] m_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] blank_model(input logic [31:0] c, input logic [31:0] v);
        logic [7:0] m;
        if (!c[16]) return 8'hFF;
        m = c[15:8];
        if (c[1]) begin
            for (int i = 1; i < 8; i++) begin
                if ((v >> (4 * i)) == 32'd0) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] dec_model(input logic [31:0] d);
        longint unsigned v;
        logic [31:0]     r;
        v = longint'(d);
        if (v > 64'd99999999) return 32'hFFFF_FFFF;
        r = 32'h0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Monitor: every ack and every display pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            if (rq.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                check("r_data", r_data, e.val);
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (disp_valid) begin
            if (dq.size() == 0) begin
                check("unexpected_disp_valid", disp_val, 32'hDEAD_BEEF);
            end else begin
                e = dq.pop_front();
                check("disp_val", disp_val, e.val);
                check("disp_blank", 32'(disp_blank), 32'(e.blank));
                check("disp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] er);
        sel   = 1'b1;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        rq.push_back('{er, 8'h00, cyc + 1});
        if (w && a == 4'h4) m_ctrl = d & 32'h0001_FF03;
        if (w && a == 4'h0) m_data = d;
        @(negedge clk);
        sel = 1'b0;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr_data(input logic [31:0] d, input bit push);
        logic [31:0] v;
        if (push) begin
            v = m_ctrl[0] ? dec_model(d) : d;
            dq.push_back('{v, blank_model(m_ctrl, v), cyc + (m_ctrl[0] ? 35 : 2)});
        end
        xfer(1'b1, 4'h0, d, 32'h0);
    endtask

    task automatic wr_ctrl(input logic [31:0] d, input bit push);
        logic [31:0] c;
        logic [31:0] v;
        c = d & 32'h0001_FF03;
        if (push) begin
            v = c[0] ? dec_model(m_data) : m_data;
            dq.push_back('{v, blank_model(c, v), cyc + (c[0] ? 35 : 2)});
        end
        xfer(1'b1, 4'h4, d, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'h8, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 4'h4, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 4'h4, 32'hFFFF_FFFE, 32'h0};
        tbl[4]  = '{1'b0, 4'h4, 32'h0, 32'h0001_FF02};
        tbl[5]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, 4'h8, 32'h0, 32'h0};
        tbl[7]  = '{1'b1, 4'hC, 32'h0000_1234, 32'h0};
        tbl[8]  = '{1'b0, 4'hC, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 4'h2, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 4'h4, 32'h0001_0000, 32'h0};
        tbl[11] = '{1'b1, 4'h0, 32'h1234_ABCD, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 32'h0, 32'h1234_ABCD};
        tbl[13] = '{1'b1, 4'h4, 32'h0001_0002, 32'h0};
        tbl[14] = '{1'b1, 4'h0, 32'h0000_0F00, 32'h0};
        tbl[15] = '{1'b0, 4'h4, 32'h0, 32'h0001_0002};
        tbl[16] = '{1'b1, 4'h4, 32'h0001_A500, 32'h0};
        tbl[17] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0};
        tbl[18] = '{1'b0, 4'h8, 32'h0, 32'h0};

        idle(3);
        check("rst_disp_val", disp_val, 32'h0);
        check("rst_disp_blank", 32'(disp_blank), 32'hFF);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_r_data", r_data, 32'h0);
        check("rst_disp_valid", 32'(disp_valid), 32'h0);
        rst = 1'b0;

        // Register map and hex-mode loads
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].w && tbl[i].a == 4'h0) wr_data(tbl[i].d, 1'b1);
            else xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er);
        end
        idle(5);

        // Decimal conversion: mode-change trigger aborted by the DATA write, BUSY window polled
        wr_ctrl(32'h0001_0001, 1'b0);
        wr_data(32'h00BC_614E, 1'b1);
        for (int k = 0; k < 40; k++) begin
            xfer(1'b0, 4'h8, 32'h0, (k >= 1 && k <= 33) ? 32'h1 : 32'h0);
        end
        check("dec_result", disp_val, 32'h1234_5678);

        // Decimal overflow
        wr_data(32'h05F5_E100, 1'b1);
        idle(40);
        xfer(1'b0, 4'h8, 32'h0, 32'h2);
        idle(2);
        check("ovf_val", disp_val, 32'hFFFF_FFFF);

        // Leading-zero blanking in decimal mode; OVF cleared by a good load
        wr_ctrl(32'h0001_0003, 1'b0);
        wr_data(32'd42, 1'b1);
        idle(40);
        xfer(1'b0, 4'h8, 32'h0, 32'h0);
        idle(2);
        check("lzb_val", disp_val, 32'h0000_0042);
        check("lzb_blank", 32'(disp_blank), 32'hFC);

        // Restart: only the second write may produce a pulse
        wr_data(32'd5, 1'b0);
        idle(9);
        wr_data(32'd999, 1'b1);
        idle(40);
        check("restart_val", disp_val, 32'h0000_0999);

        // Switching to hex mid-conversion aborts and loads DATA directly
        wr_data(32'd123456, 1'b0);
        idle(5);
        wr_ctrl(32'h0001_0002, 1'b1);
        idle(5);
        check("abort_hex_val", disp_val, 32'h0001_E240);

        // Enable gating and BLANK mask
        wr_ctrl(32'h0000_5A00, 1'b0);
        check("en_off_blank", 32'(disp_blank), 32'hFF);
        check("en_off_val_held", disp_val, 32'h0001_E240);
        wr_ctrl(32'h0001_5A00, 1'b0);
        check("blank_mask", 32'(disp_blank), 32'h5A);

        // Reset mid-conversion with a transfer pending: no pulse, no ack
        wr_ctrl(32'h0001_5A01, 1'b0);
        idle(10);
        rst   = 1'b1;
        sel   = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 4'h8;
        @(negedge clk);
        sel = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check("rst2_disp_val", disp_val, 32'h0);
        check("rst2_disp_blank", 32'(disp_blank), 32'hFF);
        check("rst2_ack", 32'(ack), 32'h0);
        check("rst2_r_data", r_data, 32'h0);
        rst    = 1'b0;
        m_ctrl = 32'h0;
        m_data = 32'h0;
        idle(50);
        xfer(1'b0, 4'h0, 32'h0, 32'h0);
        xfer(1'b0, 4'h4, 32'h0, 32'h0);
        idle(3);
        check("rq_drained", 32'(rq.size()), 32'h0);
        check("dq_drained", 32'(dq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
